// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative CORDIC vectoring unit: magnitude and atan2 in Q8 degrees
module cordic_vector #(
  parameter int ITERATIONS = 13
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               busy,
  output logic               done,
  output logic        [16:0] mag_out,
  output logic signed [16:0] angle_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0]         LAST_ITER = 4'(ITERATIONS - 1);
  // 39797 / 2^16 ~= 1/K, the inverse of the 13-stage CORDIC gain
  localparam logic signed [17:0] GAIN_COMP = 18'sd39797;
  localparam logic signed [17:0] QUARTER   = 18'sd23040;

  state_t             state_q, state_d;
  logic signed [17:0] x_q, x_d;
  logic signed [17:0] y_q, y_d;
  logic signed [17:0] z_q, z_d;
  logic        [3:0]  i_q, i_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic        [16:0] mag_q, mag_d;
  logic signed [16:0] ang_q, ang_d;

  logic signed [17:0] x_ext, y_ext;
  logic signed [17:0] x_sh, y_sh;
  logic signed [35:0] product;

  // atan(2^-i) in degrees x256
  function automatic logic signed [17:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 18'sd11520;
      4'd1:    atan_lut = 18'sd6801;
      4'd2:    atan_lut = 18'sd3593;
      4'd3:    atan_lut = 18'sd1824;
      4'd4:    atan_lut = 18'sd916;
      4'd5:    atan_lut = 18'sd458;
      4'd6:    atan_lut = 18'sd229;
      4'd7:    atan_lut = 18'sd115;
      4'd8:    atan_lut = 18'sd57;
      4'd9:    atan_lut = 18'sd29;
      4'd10:   atan_lut = 18'sd14;
      4'd11:   atan_lut = 18'sd7;
      4'd12:   atan_lut = 18'sd4;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  // 18-bit operands leave headroom for negating -32768 and for CORDIC gain growth
  assign x_ext   = {{2{x_in[15]}}, x_in};
  assign y_ext   = {{2{y_in[15]}}, y_in};
  assign x_sh    = x_q >>> i_q;
  assign y_sh    = y_q >>> i_q;
  assign product = x_q * GAIN_COMP;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mag_out   = mag_q;
  assign angle_out = ang_q;

  // next-state logic for the IDLE -> ITER -> OUT sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (i_q == LAST_ITER) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: load with quadrant pre-rotation, micro-rotate, then scale and publish
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    i_d    = i_q;
    zero_d = zero_q;
    done_d = 1'b0;
    mag_d  = mag_q;
    ang_d  = ang_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d    = 4'd0;
          zero_d = (x_in == 16'sd0) && (y_in == 16'sd0);
          if (x_in[15] && !y_in[15]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = QUARTER;
          end else if (x_in[15]) begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -QUARTER;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = 18'sd0;
          end
        end
      end
      ITER: begin
        if (!y_q[17]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(i_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(i_q);
        end
        i_d = i_q + 4'd1;
      end
      OUT: begin
        done_d = 1'b1;
        // a zero vector would otherwise accumulate the whole atan table into z
        mag_d  = zero_q ? 17'd0 : 17'(product >>> 16);
        ang_d  = zero_q ? 17'sd0 : z_q[16:0];
      end
      default: ;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      x_q     <= 18'sd0;
      y_q     <= 18'sd0;
      z_q     <= 18'sd0;
      i_q     <= 4'd0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= 17'd0;
      ang_q   <= 17'sd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// tb/tb_cordic_vector.sv - self-checking bench for cordic_vector
module tb_cordic_vector;

  localparam int  ITERATIONS = 13;
  localparam int  LATENCY    = ITERATIONS + 1;
  localparam int  PERIOD     = ITERATIONS + 2;
  localparam real PI         = 3.14159265358979;

  logic               CLK;
  logic               RST_N;
  logic               start;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               busy;
  logic               done;
  logic        [16:0] mag_out;
  logic signed [16:0] angle_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
    int                 mag;
    int                 ang;
    int                 tol_m;
    int                 tol_a;
  } vec_t;

  cordic_vector #(.ITERATIONS(ITERATIONS)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .mag_out   (mag_out),
    .angle_out (angle_out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    int diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // ideal polar conversion: true sqrt and atan2 in degrees x256
  task automatic ref_polar(input int x, input int y, output int m, output int a);
    real rx, ry;
    rx = real'(x);
    ry = real'(y);
    m  = rnd($sqrt(rx * rx + ry * ry));
    a  = (x == 0 && y == 0) ? 0 : rnd($atan2(ry, rx) * 180.0 / PI * 256.0);
  endtask

  // one request; inputs are scrambled right after the accepting edge
  task automatic do_req(input logic signed [15:0] xv, input logic signed [15:0] yv,
                        output int lat, output int m, output int a,
                        output logic busy1, output logic done_after);
    int   n;
    logic got;
    @(negedge CLK);
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    x_in  = 16'($urandom);
    y_in  = 16'($urandom);
    busy1 = busy;
    n     = 0;
    got   = 1'b0;
    while (!got && n < 40) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      got = (done === 1'b1);
    end
    lat = got ? n : -1;
    m   = int'(mag_out);
    a   = int'(angle_out);
    @(negedge CLK);
    done_after = done;
  endtask

  initial begin
    vec_t               tab [8];
    int                 lat, m, a, em, ea;
    logic               b1, d2;
    logic signed [15:0] rx, ry;
    int                 dt[$];
    int                 dm[$];
    int                 da[$];
    int                 nd, nb;

    tab[0] = '{16'sd16384,  16'sd0,      16384,  0,      16, 8};
    tab[1] = '{16'sd0,      16'sd16384,  16384,  23040,  16, 8};
    tab[2] = '{-16'sd16384, 16'sd0,      16384,  46080,  16, 8};
    tab[3] = '{-16'sd16384, -16'sd16384, 23170,  -34560, 24, 8};
    tab[4] = '{16'sh8000,   16'sh8000,   46341,  -34560, 48, 8};
    tab[5] = '{16'sd0,      16'sd0,      0,      0,      0,  0};
    tab[6] = '{16'sd0,      -16'sd16384, 16384,  -23040, 16, 8};
    tab[7] = '{16'sd16384,  16'sd16384,  23170,  11520,  24, 8};

    RST_N = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    #12;
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_mag", int'(mag_out), 0);
    check_eq("reset_ang", int'(angle_out), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      do_req(tab[i].x, tab[i].y, lat, m, a, b1, d2);
      check_eq($sformatf("dir%0d_latency", i), lat, LATENCY);
      check_eq($sformatf("dir%0d_busy", i), int'(b1), 1);
      check_eq($sformatf("dir%0d_done_pulse", i), int'(d2), 0);
      check_near($sformatf("dir%0d_mag", i), m, tab[i].mag, tab[i].tol_m);
      check_near($sformatf("dir%0d_ang", i), a, tab[i].ang, tab[i].tol_a);
    end

    // randomized vectors of reasonable length against the ideal model
    for (int i = 0; i < 20; i++) begin
      do begin
        rx = 16'($urandom);
        ry = 16'($urandom);
      end while ((real'(rx) * real'(rx) + real'(ry) * real'(ry)) < 8192.0 * 8192.0);
      ref_polar(int'(rx), int'(ry), em, ea);
      do_req(rx, ry, lat, m, a, b1, d2);
      check_eq($sformatf("rnd%0d_latency", i), lat, LATENCY);
      check_near($sformatf("rnd%0d_mag", i), m, em, 8 + em / 2048);
      check_near($sformatf("rnd%0d_ang", i), a, ea, 12);
    end

    // start held high: one result per PERIOD, mid-flight input changes ignored
    @(negedge CLK);
    x_in  = 16'sd20000;
    y_in  = -16'sd9000;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    x_in = -16'sd12000;
    y_in = 16'sd25000;
    for (int t = 1; t <= 60; t++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (done === 1'b1) begin
        dt.push_back(t);
        dm.push_back(int'(mag_out));
        da.push_back(int'(angle_out));
      end
      if (t == 3 * PERIOD - 1) start = 1'b0;
    end
    check_eq("b2b_count", dt.size(), 3);
    if (dt.size() == 3) begin
      check_eq("b2b_first", dt[0], LATENCY);
      check_eq("b2b_gap1", dt[1] - dt[0], PERIOD);
      check_eq("b2b_gap2", dt[2] - dt[1], PERIOD);
      ref_polar(20000, -9000, em, ea);
      check_near("b2b_mag0", dm[0], em, 8 + em / 2048);
      check_near("b2b_ang0", da[0], ea, 12);
      ref_polar(-12000, 25000, em, ea);
      check_near("b2b_mag1", dm[1], em, 8 + em / 2048);
      check_near("b2b_ang1", da[1], ea, 12);
    end

    // reset in the middle of the iterations
    @(negedge CLK);
    x_in  = -16'sd20000;
    y_in  = 16'sd10000;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (6) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    start = 1'b1;
    #1;
    check_eq("rst_mid_busy", int'(busy), 0);
    check_eq("rst_mid_done", int'(done), 0);
    check_eq("rst_mid_mag", int'(mag_out), 0);
    check_eq("rst_mid_ang", int'(angle_out), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    start = 1'b0;
    nd = 0;
    nb = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (done !== 1'b0) nd++;
      if (busy !== 1'b0) nb++;
    end
    check_eq("rst_no_done", nd, 0);
    check_eq("rst_no_busy", nb, 0);
    ref_polar(-20000, 10000, em, ea);
    do_req(-16'sd20000, 16'sd10000, lat, m, a, b1, d2);
    check_eq("post_rst_latency", lat, LATENCY);
    check_near("post_rst_mag", m, em, 8 + em / 2048);
    check_near("post_rst_ang", a, ea, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
